interleaver_commutator: RTL
===========================

# interleaver_commutator

Sequencer for the byte-wide convolutional interleaver. It steps a commutator across `NUM_BRANCHES` delay branches: branch k is a chained register delay line of k·`DEPTH_M` stages, so branch 11 is 187 stages for the default 12×17 geometry. For each accepted byte it asserts exactly one branch `buf_en`, broadcasts the byte to the branches, muxes the selected branch output back and presents it as the interleaved stream. It also tracks priming and realigns the commutator on packet sync.

## Interface
Parameters:
- `NUM_BRANCHES`, 12, number of commutator positions; branch 0 is a zero-delay bypass.
- `DEPTH_M`, 17, delay increment per branch, in bytes.
- `DATA_W`, 8, byte width.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  input byte qualifier.
- `in_data`  in  DATA_W  input byte.
- `in_sop`  in  1  first (sync) byte of a packet; meaningful only with `in_valid`.
- `buf_en`  out  NUM_BRANCHES  one-hot shift enable to the branch delay lines; bit 0 unused (drives 0).
- `buf_data`  out  DATA_W  byte broadcast to all branch `data_in`.
- `branch_dout`  in  NUM_BRANCHES*DATA_W  branch k `data_out` on bits [k*DATA_W +: DATA_W]; slice 0 ignored.
- `out_valid`  out  1  interleaved byte qualifier.
- `out_data`  out  DATA_W  interleaved byte.
- `out_sop`  out  1  marks the output byte that came from an input `in_sop` byte.
- `branch_sel`  out  clog2(NUM_BRANCHES)  current commutator position (debug).
- `primed`  out  1  high once every branch holds only real data.
- `sync_err`  out  1  one-cycle pulse when `in_sop` arrives with `branch_sel`≠0.

## Operation
- Stage 1, on an accepted byte (`in_valid`=1):
  - register `in_data` into `buf_data`, `in_sop` into the sop pipe, and the current position into the stage-1 select;
  - then advance `branch_sel` to (sel+1) mod NUM_BRANCHES.
- Sync realignment: if `in_sop`=1 and `branch_sel`≠0, the byte is steered to branch 0, `branch_sel` becomes 1, and `sync_err` pulses in the following cycle. If `in_sop`=1 and `branch_sel`=0, behaviour is normal with no error.
- Stage 2, in the cycle after acceptance:
  - `buf_en` is one-hot at the stage-1 select, or all-zero for select 0;
  - `out_data` registers `branch_dout[select]`, sampled before the shift edge, which is the byte written k·DEPTH_M enables earlier on that branch;
  - for select 0, `out_data` registers `buf_data` directly.
- `in_valid`=0 is a bubble: no `buf_en` and no `out_valid` two cycles later; the commutator holds.
- Priming counter: counts accepted bytes up to NUM_BRANCHES·(NUM_BRANCHES−1)·DEPTH_M (2244 by default), then saturates. `primed` goes high on the cycle the counter reaches that value and stays high. A sync realignment does not clear it.
- Counter widths are sized with clog2 from the parameters; position wrap is an explicit compare with NUM_BRANCHES−1, not a power-of-two mask.

## Timing
- Latency: input byte at edge t → `buf_en`/`buf_data` valid during cycle t+1 → `out_valid`/`out_data`/`out_sop` valid after edge t+2.
- Throughput: one byte per cycle, sustained.
- `buf_en` and `out_valid` are asserted in the same relation every cycle, with no gaps beyond the input gaps.
- Reset values: `buf_en`=0, `buf_data`=0, `out_valid`=0, `out_data`=0, `out_sop`=0, `branch_sel`=0, `primed`=0, `sync_err`=0, priming counter 0.
- Reset mid-stream: all pipeline bytes in flight are discarded, with no `out_valid` until two cycles after the first post-reset `in_valid`. Branch contents are not cleared by this block; they clear through the shared `reset`.
- Simultaneous `in_sop` and wrap (sel = NUM_BRANCHES−1): treated as misalignment, so `sync_err` pulses and the byte goes to branch 0.

## Structure
- Shared interleaver package holds the default geometry constants (`NUM_BRANCHES`, `DEPTH_M`, `DATA_W`) and a function for the prime count NUM_BRANCHES·(NUM_BRANCHES−1)·DEPTH_M.
- One natural sub-module: `branch_out_mux`, a registered NUM_BRANCHES:1 byte mux with the bypass input for select 0.
- Branch delay lines are instantiated by the top-level interleaver, not inside this block.

## Test plan
- Reset release, then 24 consecutive bytes 0x00..0x17 with `in_sop` on 0x00:
  - `buf_en` sequence is 0, 0x002, 0x004 … 0x800, then repeats;
  - the first output is 0x00 at t+2;
  - `branch_sel` wraps 11→0.
- Full interleaver with behavioural branches, 3000 incrementing bytes:
  - `primed` rises exactly on accepted byte 2244;
  - after that, each output byte equals the input from 12·k·17 bytes earlier for branch k.
- `in_valid` toggled 1,0,0,1: `out_valid` follows 2 cycles later with identical gaps and the commutator does not advance on the gaps.
- `in_sop` injected at `branch_sel`=5:
  - `sync_err` pulses for one cycle;
  - the byte appears with `buf_en`=0 (branch 0) and `out_sop`=1;
  - `branch_sel` becomes 1;
  - `primed` is unchanged.
- `reset` asserted asynchronously mid-packet between edges:
  - all outputs go to 0 immediately, without waiting for a clock edge;
  - after release the next byte goes to branch 0.

Source files
------------

// File: rtl/interleaver_commutator_pkg.sv
// -----------------------------------------------------------------------------
// interleaver_commutator_pkg
// Shared geometry for the byte-wide convolutional interleaver.
//   NUM_BRANCHES_DEF : commutator positions (branch 0 is a zero-delay bypass)
//   DEPTH_M_DEF      : delay increment per branch, in bytes
//   DATA_W_DEF       : byte width
//   prime_count()    : bytes needed before every branch holds only real data
// -----------------------------------------------------------------------------
package interleaver_commutator_pkg;

    localparam int NUM_BRANCHES_DEF = 12;
    localparam int DEPTH_M_DEF      = 17;
    localparam int DATA_W_DEF       = 8;

    // The longest branch (NB-1)*M is filled once NB*(NB-1)*M bytes have been
    // accepted, because each branch is visited once every NB bytes.
    function automatic int prime_count(input int num_branches, input int depth_m);
        return num_branches * (num_branches - 1) * depth_m;
    endfunction

endpackage

// File: rtl/interleaver_commutator_branch_out_mux.sv
// -----------------------------------------------------------------------------
// branch_out_mux
// Registered NUM_BRANCHES:1 byte mux. Select 0 takes the bypass byte; any
// other select takes that branch's data_out slice.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   vld          : stage-1 byte qualifier
//   sel          : stage-1 commutator position
//   sop          : stage-1 start-of-packet flag
//   bypass       : stage-1 byte (branch 0 path)
//   branch_dout  : all branch outputs, branch k at [k*DATA_W +: DATA_W]
//   out_valid, out_data, out_sop : registered interleaved stream
// -----------------------------------------------------------------------------
module branch_out_mux #(
    parameter int NUM_BRANCHES = 12,
    parameter int DATA_W       = 8,
    parameter int SEL_W        = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           vld,
    input  logic [SEL_W-1:0]               sel,
    input  logic                           sop,
    input  logic [DATA_W-1:0]              bypass,
    input  logic [NUM_BRANCHES*DATA_W-1:0] branch_dout,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_sop
);

    logic [DATA_W-1:0] picked;
    logic              unused_slice0;

    // Branch 0 has no delay line, so its slice carries nothing meaningful.
    assign unused_slice0 = ^branch_dout[DATA_W-1:0];

    always_comb begin
        picked = bypass;
        for (int k = 1; k < NUM_BRANCHES; k++) begin
            if (sel == SEL_W'(k)) begin
                picked = branch_dout[k*DATA_W +: DATA_W];
            end
        end
    end

    // Sampled on the same edge the selected branch shifts, so the value taken
    // is the branch tail before the new byte pushes it out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
        end else begin
            out_valid <= vld;
            out_sop   <= vld & sop;
            if (vld) begin
                out_data <= picked;
            end
        end
    end

endmodule

// File: rtl/interleaver_commutator.sv
// -----------------------------------------------------------------------------
// interleaver_commutator
// Commutator sequencer for the convolutional interleaver. Each accepted byte
// is broadcast to the branch delay lines with exactly one branch shift enable,
// and the selected branch tail is muxed back as the interleaved stream.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   in_valid/in_data/in_sop : input byte stream
//   buf_en       : one-hot branch shift enable (bit 0 always 0)
//   buf_data     : byte broadcast to every branch data_in
//   branch_dout  : branch tails, branch k at [k*DATA_W +: DATA_W]
//   out_valid/out_data/out_sop : interleaved stream, two cycles after input
//   branch_sel   : current commutator position
//   primed       : every branch holds only real data
//   sync_err     : in_sop arrived off position 0 (commutator realigned)
// -----------------------------------------------------------------------------
module interleaver_commutator
    import interleaver_commutator_pkg::*;
#(
    parameter int NUM_BRANCHES = NUM_BRANCHES_DEF,
    parameter int DEPTH_M      = DEPTH_M_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    localparam int SEL_W       = $clog2(NUM_BRANCHES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_sop,
    output logic [NUM_BRANCHES-1:0]        buf_en,
    output logic [DATA_W-1:0]              buf_data,
    input  logic [NUM_BRANCHES*DATA_W-1:0] branch_dout,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_sop,
    output logic [SEL_W-1:0]               branch_sel,
    output logic                           primed,
    output logic                           sync_err
);

    localparam int PRIME = prime_count(NUM_BRANCHES, DEPTH_M);
    localparam int CNT_W = $clog2(PRIME + 1);

    logic             realign;
    logic [SEL_W-1:0] sel_now;
    logic [SEL_W-1:0] sel_p1;
    logic             vld_p1;
    logic             sop_p1;
    logic [CNT_W-1:0] prime_cnt;

    // A sync byte off position 0 is forced onto the bypass branch so the
    // packet start always lands at position 0.
    always_comb begin
        realign = in_valid && in_sop && (branch_sel != '0);
        sel_now = realign ? '0 : branch_sel;
    end

    // ---- stage 1: accept byte, advance commutator ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            sop_p1     <= 1'b0;
            sel_p1     <= '0;
            buf_data   <= '0;
            branch_sel <= '0;
            sync_err   <= 1'b0;
            prime_cnt  <= '0;
            primed     <= 1'b0;
        end else begin
            vld_p1   <= in_valid;
            sync_err <= realign;
            if (in_valid) begin
                buf_data   <= in_data;
                sop_p1     <= in_sop;
                sel_p1     <= sel_now;
                branch_sel <= (sel_now == SEL_W'(NUM_BRANCHES - 1)) ? '0
                                                                    : sel_now + SEL_W'(1);
                if (prime_cnt != CNT_W'(PRIME)) begin
                    prime_cnt <= prime_cnt + CNT_W'(1);
                end
                if (prime_cnt == CNT_W'(PRIME - 1)) begin
                    primed <= 1'b1;
                end
            end
        end
    end

    // ---- stage 2: shift enable to the selected branch, registered read-back ----
    always_comb begin
        buf_en = '0;
        for (int k = 1; k < NUM_BRANCHES; k++) begin
            if (vld_p1 && (sel_p1 == SEL_W'(k))) begin
                buf_en[k] = 1'b1;
            end
        end
    end

    branch_out_mux #(
        .NUM_BRANCHES (NUM_BRANCHES),
        .DATA_W       (DATA_W),
        .SEL_W        (SEL_W)
    ) u_branch_out_mux (
        .clk         (clk),
        .reset       (reset),
        .vld         (vld_p1),
        .sel         (sel_p1),
        .sop         (sop_p1),
        .bypass      (buf_data),
        .branch_dout (branch_dout),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sop     (out_sop)
    );

endmodule
